// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: operation codes,
// controller state encodings and the initial-carry rule.
package serial_addsub_pkg;

  // Operation codes presented on the mode input
  localparam logic [1:0] ModeAdd = 2'b00;
  localparam logic [1:0] ModeSub = 2'b01;
  localparam logic [1:0] ModeNeg = 2'b10;
  localparam logic [1:0] ModeAbs = 2'b11;

  // Controller states
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Carry seeded into bit 0: the +1 of two's-complement inversion, applied for
  // subtract, negate, and absolute value of a negative operand.
  function automatic logic init_carry(input logic [1:0] mode, input logic a_msb);
    logic c;
    c = 1'b0;
    case (mode)
      ModeSub: c = 1'b1;
      ModeNeg: c = 1'b1;
      ModeAbs: c = a_msb;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder used as the single arithmetic slice of the serial unit.
module serial_addsub_full_adder (
  input  logic Bit1,
  input  logic Bit2,
  input  logic Cin,
  output logic Y,
  output logic Cout
);

  // Sum and carry of three input bits
  always_comb begin
    Y    = Bit1 ^ Bit2 ^ Cin;
    Cout = (Bit1 & Bit2) | (Cin & (Bit1 ^ Bit2));
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add / subtract / negate / absolute-value unit. Operands are
// consumed LSB first through one full-adder slice, one bit per clock.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [1:0]       mode_q, mode_d;
  logic             a_msb_q, a_msb_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic x_bit, y_bit, sum_bit, cout_bit;

  // Per-bit adder operands selected by the latched operation
  always_comb begin
    x_bit = a_sh_q[0];
    y_bit = 1'b0;
    unique case (mode_q)
      ModeAdd: begin
        x_bit = a_sh_q[0];
        y_bit = b_sh_q[0];
      end
      ModeSub: begin
        x_bit = a_sh_q[0];
        y_bit = ~b_sh_q[0];
      end
      ModeNeg: begin
        x_bit = ~a_sh_q[0];
        y_bit = 1'b0;
      end
      ModeAbs: begin
        // Invert only when the captured operand is negative
        x_bit = a_msb_q ? ~a_sh_q[0] : a_sh_q[0];
        y_bit = 1'b0;
      end
    endcase
  end

  serial_addsub_full_adder u_slice (
    .Bit1 (x_bit),
    .Bit2 (y_bit),
    .Cin  (carry_q),
    .Y    (sum_bit),
    .Cout (cout_bit)
  );

  // Controller next-state: capture, shift one bit per cycle, then publish
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    mode_d      = mode_q;
    a_msb_d     = a_msb_q;
    carry_d     = carry_q;
    cin_msb_d   = cin_msb_q;
    count_d     = count_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          a_sh_d  = a;
          b_sh_d  = b;
          mode_d  = mode;
          a_msb_d = a[WIDTH-1];
          carry_d = init_carry(mode, a[WIDTH-1]);
          count_d = '0;
        end
      end
      StShift: begin
        res_sh_d = {sum_bit, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = cout_bit;
        count_d  = count_q + CntW'(1);
        if (count_q == LastCnt) begin
          // Carry into the MSB, kept for the overflow flag
          cin_msb_d = carry_q;
          state_d   = StDone;
        end
      end
      StDone: begin
        result_d    = res_sh_q;
        carry_out_d = carry_q;
        overflow_d  = cin_msb_q ^ carry_q;
        done_d      = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      mode_q      <= '0;
      a_msb_q     <= 1'b0;
      carry_q     <= 1'b0;
      cin_msb_q   <= 1'b0;
      count_q     <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      mode_q      <= mode_d;
      a_msb_q     <= a_msb_d;
      carry_q     <= carry_d;
      cin_msb_q   <= cin_msb_d;
      count_q     <= count_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    busy      = (state_q == StShift);
    done      = done_q;
    result    = result_q;
    carry_out = carry_out_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed boundary cases, random
// operations, back-to-back issue, protocol corner cases and a 4-bit instance.
module tb_serial_addsub;

  localparam int W = 8;
  localparam int P = W + 2;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] result;
  logic       carry_out, overflow;

  logic       start4;
  logic [1:0] mode4;
  logic [3:0] a4, b4;
  logic       busy4, done4;
  logic [3:0] result4;
  logic       carry_out4, overflow4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start4),
    .mode      (mode4),
    .a         (a4),
    .b         (b4),
    .busy      (busy4),
    .done      (done4),
    .result    (result4),
    .carry_out (carry_out4),
    .overflow  (overflow4)
  );

  // Arithmetic reference: result, carry and signed overflow from plain integers
  function automatic void model(input int w, input int md, input int av, input int bv,
                                output int res, output int cy, output int ov);
    int mask, sgn;
    mask = (1 << w) - 1;
    sgn  = 1 << (w - 1);
    case (md)
      0: begin
        res = (av + bv) & mask;
        cy  = ((av + bv) > mask) ? 1 : 0;
        ov  = (((av & sgn) == (bv & sgn)) && ((res & sgn) != (av & sgn))) ? 1 : 0;
      end
      1: begin
        res = (av - bv) & mask;
        cy  = (av >= bv) ? 1 : 0;
        ov  = (((av & sgn) != (bv & sgn)) && ((res & sgn) != (av & sgn))) ? 1 : 0;
      end
      2: begin
        res = (-av) & mask;
        cy  = (av == 0) ? 1 : 0;
        ov  = (av == sgn) ? 1 : 0;
      end
      default: begin
        res = ((av & sgn) != 0) ? ((-av) & mask) : av;
        cy  = 0;
        ov  = (av == sgn) ? 1 : 0;
      end
    endcase
  endfunction

  // Issue one operation on the 8-bit DUT and observe it for a bounded window
  task automatic run_op8(input logic [1:0] md, input logic [7:0] av, input logic [7:0] bv,
                         output logic [7:0] r, output logic cy, output logic ov,
                         output int done_at, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    start = 1'b1; mode = md; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
    busy_cnt = busy ? 1 : 0;
    done_at  = -1;
    done_cnt = 0;
    r = '0; cy = 1'b0; ov = 1'b0;
    for (int k = 1; k <= W + 5; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k; r = result; cy = carry_out; ov = overflow;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", done); end
    n_chk++; if (result !== 8'h00) begin n_err++; $display("FAIL reset result: got %h want 00", result); end
    n_chk++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL reset carry_out: got %b want 0", carry_out); end
    n_chk++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b want 0", overflow); end
    n_chk++; if (result4 !== 4'h0 || done4 !== 1'b0) begin
      n_err++; $display("FAIL reset w4: got result %h done %b want 0 0", result4, done4);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int dm [8] = '{1, 0, 2, 2, 2, 3, 3, 3};
    int da [8] = '{'h05, 'h7f, 'h01, 'h80, 'h00, 'hf6, 'h35, 'h80};
    int db [8] = '{'h03, 'h01, 'h5a, 'h00, 'hff, 'h11, 'h00, 'h22};
    logic [7:0] r; logic cy, ov; int dat, bc, dc, er, ec, eo;
    for (int i = 0; i < 8; i++) begin
      run_op8(2'(dm[i]), 8'(da[i]), 8'(db[i]), r, cy, ov, dat, bc, dc);
      model(8, dm[i], da[i], db[i], er, ec, eo);
      n_chk++; if (r !== 8'(er)) begin n_err++; $display("FAIL directed[%0d] result: got %h want %h", i, r, 8'(er)); end
      if (dm[i] != 3) begin
        n_chk++; if (cy !== 1'(ec)) begin n_err++; $display("FAIL directed[%0d] carry_out: got %b want %0d", i, cy, ec); end
      end
      n_chk++; if (ov !== 1'(eo)) begin n_err++; $display("FAIL directed[%0d] overflow: got %b want %0d", i, ov, eo); end
      n_chk++; if (dat != W + 1) begin n_err++; $display("FAIL directed[%0d] done edge: got %0d want %0d", i, dat, W + 1); end
      n_chk++; if (bc != W) begin n_err++; $display("FAIL directed[%0d] busy cycles: got %0d want %0d", i, bc, W); end
      n_chk++; if (dc != 1) begin n_err++; $display("FAIL directed[%0d] done pulses: got %0d want 1", i, dc); end
    end
  endtask

  task automatic test_random();
    logic [7:0] r, ra, rb; logic [1:0] rm; logic cy, ov; int dat, bc, dc, er, ec, eo;
    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom); ra = 8'($urandom); rb = 8'($urandom);
      if (i % 8 == 0) ra = 8'h80;
      run_op8(rm, ra, rb, r, cy, ov, dat, bc, dc);
      model(8, int'(rm), int'(ra), int'(rb), er, ec, eo);
      n_chk++; if (r !== 8'(er)) begin n_err++; $display("FAIL random[%0d] m%0d a=%h b=%h result: got %h want %h", i, rm, ra, rb, r, 8'(er)); end
      if (rm != 2'b11) begin
        n_chk++; if (cy !== 1'(ec)) begin n_err++; $display("FAIL random[%0d] carry_out: got %b want %0d", i, cy, ec); end
      end
      n_chk++; if (ov !== 1'(eo)) begin n_err++; $display("FAIL random[%0d] overflow: got %b want %0d", i, ov, eo); end
      n_chk++; if (dat != W + 1 || dc != 1) begin
        n_err++; $display("FAIL random[%0d] done: got edge %0d count %0d want %0d 1", i, dat, dc, W + 1);
      end
    end
  endtask

  // start held high with operands changing every cycle: only those present at
  // each acceptance edge (every W+2 cycles) may reach the result
  task automatic test_back_to_back();
    logic [1:0] om [64]; logic [7:0] oa [64], ob [64];
    int last, held, have, er, ec, eo, src;
    logic exp_done;
    last = 2 * P + W + 2;
    have = 0; held = 0;
    @(negedge clk);
    for (int e = 0; e <= last; e++) begin
      start = (e <= 2 * P);
      om[e] = 2'($urandom); oa[e] = 8'($urandom); ob[e] = 8'($urandom);
      mode = om[e]; a = oa[e]; b = ob[e];
      @(negedge clk);
      exp_done = (e >= W + 1) && (((e - (W + 1)) % P) == 0) && (((e - (W + 1)) / P) <= 2);
      n_chk++; if (done !== exp_done) begin n_err++; $display("FAIL b2b done at edge %0d: got %b want %b", e, done, exp_done); end
      if (exp_done) begin
        src = e - (W + 1);
        model(8, int'(om[src]), int'(oa[src]), int'(ob[src]), er, ec, eo);
        n_chk++; if (result !== 8'(er)) begin n_err++; $display("FAIL b2b result edge %0d: got %h want %h", e, result, 8'(er)); end
        n_chk++; if (overflow !== 1'(eo)) begin n_err++; $display("FAIL b2b overflow edge %0d: got %b want %0d", e, overflow, eo); end
        if (om[src] != 2'b11) begin
          n_chk++; if (carry_out !== 1'(ec)) begin n_err++; $display("FAIL b2b carry_out edge %0d: got %b want %0d", e, carry_out, ec); end
        end
        held = er; have = 1;
      end else if (have != 0) begin
        n_chk++; if (result !== 8'(held)) begin n_err++; $display("FAIL b2b result hold edge %0d: got %h want %h", e, result, 8'(held)); end
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_protocol();
    logic [7:0] r; logic cy, ov; int dat, dc, bc, er, ec, eo;
    // Start pulse during busy cycle 3 must be ignored
    @(negedge clk);
    start = 1'b1; mode = 2'b01; a = 8'h05; b = 8'h03;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; mode = 2'b00; a = 8'h70; b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    dat = -1; dc = 0; r = '0;
    for (int k = 4; k <= 25; k++) begin
      @(negedge clk);
      if (done) begin dc++; if (dat < 0) begin dat = k; r = result; end end
    end
    n_chk++; if (r !== 8'h02) begin n_err++; $display("FAIL ignored start result: got %h want 02", r); end
    n_chk++; if (dat != W + 1 || dc != 1) begin
      n_err++; $display("FAIL ignored start done: got edge %0d count %0d want %0d 1", dat, dc, W + 1);
    end
    // Reset during busy cycle 4 aborts with no done
    @(negedge clk);
    start = 1'b1; mode = 2'b00; a = 8'h7f; b = 8'h7f;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL abort busy/done: got %b %b want 0 0", busy, done);
    end
    n_chk++; if (result !== 8'h00 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL abort outputs: got %h %b %b want 00 0 0", result, carry_out, overflow);
    end
    dc = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) dc++;
    end
    n_chk++; if (dc != 0) begin n_err++; $display("FAIL abort stray done: got %0d want 0", dc); end
    // A fresh operation after the abort completes normally
    run_op8(2'b00, 8'h7f, 8'h01, r, cy, ov, dat, bc, dc);
    model(8, 0, 'h7f, 'h01, er, ec, eo);
    n_chk++; if (r !== 8'(er) || cy !== 1'(ec) || ov !== 1'(eo)) begin
      n_err++; $display("FAIL post-abort op: got %h %b %b want %h %0d %0d", r, cy, ov, 8'(er), ec, eo);
    end
    n_chk++; if (dat != W + 1) begin n_err++; $display("FAIL post-abort done edge: got %0d want %0d", dat, W + 1); end
  endtask

  task automatic test_width4();
    int dat, bc, er, ec, eo;
    logic [3:0] r; logic cy, ov;
    @(negedge clk);
    start4 = 1'b1; mode4 = 2'b01; a4 = 4'h3; b4 = 4'h5;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'hf; b4 = 4'h0;
    bc = busy4 ? 1 : 0; dat = -1; r = '0; cy = 1'b0; ov = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy4) bc++;
      if (done4 && dat < 0) begin dat = k; r = result4; cy = carry_out4; ov = overflow4; end
    end
    model(4, 1, 3, 5, er, ec, eo);
    n_chk++; if (r !== 4'(er)) begin n_err++; $display("FAIL w4 result: got %h want %h", r, 4'(er)); end
    n_chk++; if (cy !== 1'(ec) || ov !== 1'(eo)) begin
      n_err++; $display("FAIL w4 flags: got c%b v%b want c%0d v%0d", cy, ov, ec, eo);
    end
    n_chk++; if (dat != 5) begin n_err++; $display("FAIL w4 done edge: got %0d want 5", dat); end
    n_chk++; if (bc != 4) begin n_err++; $display("FAIL w4 busy cycles: got %0d want 4", bc); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; a = '0; b = '0;
    start4 = 1'b0; mode4 = 2'b00; a4 = '0; b4 = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_protocol();
    test_width4();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
